// File: rtl/computer16_pkg.sv
// Shared Computer16 constants: word width, jump-condition bit layout and PC FSM states.
// Optional return-address register is enabled with `define PC_LINK_EN (see pc_branch_unit).
package computer16_pkg;

    localparam int WORD_W = 16;

    // Bit positions inside the 3-bit jmp field {lt, eq, gt}
    localparam int J_LT = 2;
    localparam int J_EQ = 1;
    localparam int J_GT = 0;

    localparam logic [2:0] JMP_NULL   = 3'b000;
    localparam logic [2:0] JMP_ALWAYS = 3'b111;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } pc_state_t;

endpackage

// File: rtl/or16_reduce.sv
// 16-bit OR reduction as a two-level tree of or4 cells (4x4 -> 4 -> 1).
module or16_reduce (
    input  logic [15:0] data,
    output logic        any
);

    logic [3:0] grp;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_leaf
            or4 u_or4 (
                .a (data[gi*4 +: 4]),
                .y (grp[gi])
            );
        end
    endgenerate

    or4 u_or4_root (
        .a (grp),
        .y (any)
    );

endmodule

// File: rtl/or4.sv
// Four-input OR gate, the leaf cell of the wide OR reduction tree.
module or4 (
    input  logic [3:0] a,
    output logic       y
);

    assign y = a[0] | a[1] | a[2] | a[3];

endmodule

// File: rtl/pc_branch_unit.sv
// Computer16 program counter with jump-condition evaluation and jump-to-self halt detection.
// Define PC_LINK_EN to add the link_addr return-address register.
module pc_branch_unit #(
    parameter int                           WORD_W   = computer16_pkg::WORD_W,
    parameter logic [computer16_pkg::WORD_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              is_c,
    input  logic [2:0]        jmp,
    input  logic [WORD_W-1:0] a_reg,
    input  logic [WORD_W-1:0] alu_out,
    output logic              zr,
    output logic              ng,
    output logic [WORD_W-1:0] pc,
    output logic              jump_taken,
    output logic              halted
`ifdef PC_LINK_EN
    ,
    output logic [WORD_W-1:0] link_addr
`endif
);

    import computer16_pkg::*;

    pc_state_t         state_reg, state_next;
    logic [WORD_W-1:0] pc_reg, pc_next;
    logic              jump_taken_reg, jump_taken_next;
    logic [WORD_W-1:0] pc_inc;
    logic              alu_any;
    logic              take;

    or16_reduce u_zero_detect (
        .data (alu_out),
        .any  (alu_any)
    );

    assign zr = ~alu_any;
    assign ng = alu_out[WORD_W-1];

    assign take = is_c & ((jmp[J_LT] & ng) | (jmp[J_EQ] & zr) | (jmp[J_GT] & ~zr & ~ng));

    // Natural overflow of the adder gives the FFFF -> 0000 wrap
    assign pc_inc = pc_reg + WORD_W'(1);

`ifdef PC_LINK_EN
    logic [WORD_W-1:0] link_reg, link_next;
`endif

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        jump_taken_next = jump_taken_reg;
`ifdef PC_LINK_EN
        link_next       = link_reg;
`endif
        case (state_reg)
            RUN: begin
                if (!stall) begin
                    if (take) begin
                        jump_taken_next = 1'b1;
`ifdef PC_LINK_EN
                        link_next       = pc_inc;
`endif
                        // A taken jump onto itself can never make progress: park the core
                        if (a_reg == pc_reg) begin
                            state_next = HALT;
                        end else begin
                            pc_next = a_reg;
                        end
                    end else begin
                        pc_next         = pc_inc;
                        jump_taken_next = 1'b0;
                    end
                end
            end
            HALT: begin
                jump_taken_next = 1'b0;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= RUN;
            pc_reg         <= RESET_PC;
            jump_taken_reg <= 1'b0;
`ifdef PC_LINK_EN
            link_reg       <= '0;
`endif
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            jump_taken_reg <= jump_taken_next;
`ifdef PC_LINK_EN
            link_reg       <= link_next;
`endif
        end
    end

    assign pc         = pc_reg;
    assign jump_taken = jump_taken_reg;
    assign halted     = (state_reg == HALT);
`ifdef PC_LINK_EN
    assign link_addr  = link_reg;
`endif

endmodule
